// File: rtl/armleocpu_tlb_sequencer.sv
// TLB command-port owner: refill/resolve arbitration, set-by-set invalidation sweep, registered responses.
// Optional hit/miss counters when ARMLEOCPU_TLB_SEQ_STATS_EN is defined.
module armleocpu_tlb_sequencer #(
  parameter int ENTRIES_W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_req,
  output logic                 flush_done,
  input  logic                 resolve_valid,
  output logic                 resolve_ready,
  input  logic [19:0]          resolve_vaddr,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [7:0]           resp_accesstag,
  output logic [21:0]          resp_phys,
  input  logic                 write_valid,
  output logic                 write_ready,
  input  logic [19:0]          write_vaddr,
  input  logic [7:0]           write_accesstag,
  input  logic [21:0]          write_phys,
  output logic [1:0]           tlb_command,
  output logic [ENTRIES_W-1:0] tlb_invalidate_set_index,
  output logic [19:0]          tlb_virtual_address,
  output logic [19:0]          tlb_virtual_address_w,
  output logic [7:0]           tlb_accesstag_w,
  output logic [21:0]          tlb_phys_w,
  input  logic                 tlb_hit,
  input  logic [7:0]           tlb_accesstag_r,
  input  logic [21:0]          tlb_phys_r
`ifdef ARMLEOCPU_TLB_SEQ_STATS_EN
  ,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses
`endif
);

  localparam logic [1:0] TLB_CMD_NONE       = 2'b00;
  localparam logic [1:0] TLB_CMD_RESOLVE    = 2'b01;
  localparam logic [1:0] TLB_CMD_WRITE      = 2'b10;
  localparam logic [1:0] TLB_CMD_INVALIDATE = 2'b11;

  typedef enum logic {
    FLUSH,
    IDLE
  } state_t;

  state_t               state, state_nxt;
  logic [ENTRIES_W-1:0] idx;
  logic                 idx_last;

  assign idx_last = (idx == '1);
  assign tlb_invalidate_set_index = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FLUSH;
      idx        <= '0;
      flush_done <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_done <= (state == FLUSH) && idx_last;
      resp_valid <= resolve_valid && resolve_ready;
      if (state == FLUSH)
        idx <= idx_last ? '0 : idx + ENTRIES_W'(1);
    end
  end

  always_comb begin
    state_nxt             = state;
    tlb_command           = TLB_CMD_NONE;
    resolve_ready         = 1'b0;
    write_ready           = 1'b0;
    tlb_virtual_address   = '0;
    tlb_virtual_address_w = '0;
    tlb_accesstag_w       = '0;
    tlb_phys_w            = '0;
    case (state)
      FLUSH: begin
        tlb_command = TLB_CMD_INVALIDATE;
        if (idx_last)
          state_nxt = IDLE;
      end
      IDLE: begin
        // Flush request wins and issues nothing this cycle, so no request is lost mid-sweep.
        if (flush_req) begin
          state_nxt = FLUSH;
        end else if (write_valid) begin
          write_ready           = 1'b1;
          tlb_command           = TLB_CMD_WRITE;
          tlb_virtual_address_w = write_vaddr;
          tlb_accesstag_w       = write_accesstag;
          tlb_phys_w            = write_phys;
        end else if (resolve_valid) begin
          resolve_ready       = 1'b1;
          tlb_command         = TLB_CMD_RESOLVE;
          tlb_virtual_address = resolve_vaddr;
        end
      end
      default: state_nxt = FLUSH;
    endcase
  end

  assign resp_hit       = resp_valid && tlb_hit;
  assign resp_accesstag = resp_valid ? tlb_accesstag_r : '0;
  assign resp_phys      = resp_valid ? tlb_phys_r : '0;

`ifdef ARMLEOCPU_TLB_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (resp_valid) begin
      if (tlb_hit) begin
        if (stat_hits != '1)
          stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1)
          stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_armleocpu_tlb_sequencer.sv
// Self-checking bench for armleocpu_tlb_sequencer: behavioural TLB stub plus a mapping-level reference model.
module tb_armleocpu_tlb_sequencer;
  localparam int ENTRIES_W = 1;
  localparam int NSETS = 1 << ENTRIES_W;
  localparam logic [1:0] CMD_NONE = 2'b00, CMD_RESOLVE = 2'b01, CMD_WRITE = 2'b10, CMD_INV = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0, flush_done;
  logic resolve_valid = 1'b0, resolve_ready;
  logic [19:0] resolve_vaddr = '0;
  logic resp_valid, resp_hit;
  logic [7:0] resp_accesstag;
  logic [21:0] resp_phys;
  logic write_valid = 1'b0, write_ready;
  logic [19:0] write_vaddr = '0;
  logic [7:0] write_accesstag = '0;
  logic [21:0] write_phys = '0;
  logic [1:0] tlb_command;
  logic [ENTRIES_W-1:0] tlb_invalidate_set_index;
  logic [19:0] tlb_virtual_address, tlb_virtual_address_w;
  logic [7:0] tlb_accesstag_w;
  logic [21:0] tlb_phys_w;
  logic tlb_hit;
  logic [7:0] tlb_accesstag_r;
  logic [21:0] tlb_phys_r;
`ifdef ARMLEOCPU_TLB_SEQ_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  armleocpu_tlb_sequencer #(.ENTRIES_W(ENTRIES_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .flush_req(flush_req), .flush_done(flush_done),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready), .resolve_vaddr(resolve_vaddr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_accesstag(resp_accesstag), .resp_phys(resp_phys),
    .write_valid(write_valid), .write_ready(write_ready), .write_vaddr(write_vaddr),
    .write_accesstag(write_accesstag), .write_phys(write_phys),
    .tlb_command(tlb_command), .tlb_invalidate_set_index(tlb_invalidate_set_index),
    .tlb_virtual_address(tlb_virtual_address), .tlb_virtual_address_w(tlb_virtual_address_w),
    .tlb_accesstag_w(tlb_accesstag_w), .tlb_phys_w(tlb_phys_w),
    .tlb_hit(tlb_hit), .tlb_accesstag_r(tlb_accesstag_r), .tlb_phys_r(tlb_phys_r)
`ifdef ARMLEOCPU_TLB_SEQ_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  // TLB stub: registered resolve outputs, garbage when not resolving so the response gating is exercised.
  bit [29:0] stub [bit [19:0]];
  always @(posedge clk) begin
    bit [19:0] victims[$];
    case (tlb_command)
      CMD_RESOLVE: begin
        if (stub.exists(tlb_virtual_address)) begin
          tlb_hit <= 1'b1;
          {tlb_accesstag_r, tlb_phys_r} <= stub[tlb_virtual_address];
        end else begin
          tlb_hit <= 1'b0;
          tlb_accesstag_r <= '0;
          tlb_phys_r <= '0;
        end
      end
      default: begin
        if (tlb_command == CMD_WRITE)
          stub[tlb_virtual_address_w] = {tlb_accesstag_w, tlb_phys_w};
        if (tlb_command == CMD_INV) begin
          foreach (stub[k]) if (k[ENTRIES_W-1:0] == tlb_invalidate_set_index) victims.push_back(k);
          foreach (victims[i]) stub.delete(victims[i]);
        end
        tlb_hit <= 1'($urandom_range(0, 1));
        tlb_accesstag_r <= 8'($urandom);
        tlb_phys_r <= 22'($urandom);
      end
    endcase
  end

  // Reference model: translations the TLB should hold, sweep progress, and the pending response.
  bit [29:0] ref_map [bit [19:0]];
  int sweep_pos;
  bit exp_done, exp_rv, exp_hit;
  bit [29:0] exp_data;
  int n_cmp = 0, n_err = 0;
  int hits = 0, misses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    sweep_pos = 0;
    exp_done = 1'b0;
    exp_rv = 1'b0;
    hits = 0;
    misses = 0;
  endtask

  task automatic drive(input bit fr, input bit wv, input logic [19:0] wva, input logic [7:0] wt,
                       input logic [21:0] wp, input bit rv, input logic [19:0] rva);
    flush_req = fr;
    write_valid = wv; write_vaddr = wva; write_accesstag = wt; write_phys = wp;
    resolve_valid = rv; resolve_vaddr = rva;
  endtask

  task automatic cycle();
    logic [1:0] cmd;
    bit wr, rr;
    logic [19:0] va, vaw;
    logic [7:0] tw;
    logic [21:0] pw;
    cmd = CMD_NONE; wr = 0; rr = 0; va = '0; vaw = '0; tw = '0; pw = '0;
    if (sweep_pos >= 0) cmd = CMD_INV;
    else if (flush_req) cmd = CMD_NONE;
    else if (write_valid) begin
      cmd = CMD_WRITE; wr = 1; vaw = write_vaddr; tw = write_accesstag; pw = write_phys;
    end else if (resolve_valid) begin
      cmd = CMD_RESOLVE; rr = 1; va = resolve_vaddr;
    end
    @(negedge clk);
    check("tlb_command", 64'(tlb_command), 64'(cmd));
    check("set_index", 64'(tlb_invalidate_set_index), 64'(sweep_pos >= 0 ? sweep_pos : 0));
    check("readies", 64'({write_ready, resolve_ready}), 64'({wr, rr}));
    check("tlb_write_data", 64'({tlb_virtual_address_w, tlb_accesstag_w, tlb_phys_w}), 64'({vaw, tw, pw}));
    check("tlb_vaddr", 64'(tlb_virtual_address), 64'(va));
    check("flush_done", 64'(flush_done), 64'(exp_done));
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv && exp_hit)
      check("resp_hit_data", 64'({resp_hit, resp_accesstag, resp_phys}), 64'({1'b1, exp_data}));
    else if (exp_rv)
      check("resp_miss", 64'(resp_hit), 64'(0));
    else
      check("resp_idle_zero", 64'({resp_hit, resp_accesstag, resp_phys}), 64'(0));
    @(posedge clk);
    if (!rst_n) begin
      sweep_pos = 0; exp_done = 0; exp_rv = 0;
    end else begin
      if (exp_rv) begin
        if (exp_hit) hits++; else misses++;
      end
      exp_done = (sweep_pos == NSETS - 1);
      exp_rv = rr;
      if (rr) begin
        exp_hit = ref_map.exists(va);
        exp_data = exp_hit ? ref_map[va] : '0;
      end
      if (wr) ref_map[vaw] = {tw, pw};
      if (sweep_pos == NSETS - 1) begin
        sweep_pos = -1;
        ref_map.delete();
      end else if (sweep_pos >= 0) sweep_pos++;
      else if (flush_req) sweep_pos = 0;
    end
    #1;
  endtask

  logic [19:0] pool [8];
  bit flush_pending;

  initial begin
    pool = '{20'h100, 20'h101, 20'h55, 20'h56, 20'h77, 20'h3a, 20'h3b, 20'hfff};
    start_reset();
    drive(1'b0, 1'b1, 20'($urandom), 8'($urandom), 22'($urandom), 1'b1, 20'($urandom));
    repeat (3) cycle();
    rst_n = 1'b1;
    // post-reset sweep: idx 0, idx 1, then flush_done with the first resolve accepted
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h55);
    repeat (3) cycle();
    drive(1'b0, 1'b1, 20'h100, 8'hFF, 22'hF5, 1'b0, '0); cycle();
    drive(1'b0, 1'b1, 20'h101, 8'hFF, 22'hF5, 1'b0, '0); cycle();
    drive(1'b0, 1'b1, 20'h55,  8'hFF, 22'hFE, 1'b0, '0); cycle();
    drive(1'b0, 1'b1, 20'h56,  8'hFF, 22'hF5, 1'b0, '0); cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h55);  cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h56);  cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h100); cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h101); cycle();
    // write and resolve together: write wins, resolve of the same page follows and sees it
    drive(1'b0, 1'b1, 20'h77, 8'hA5, 22'h12345, 1'b1, 20'h77); cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h77); cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0); cycle();
    // flush, then the earlier pages miss
    drive(1'b1, 1'b0, '0, '0, '0, 1'b1, 20'h55); repeat (3) cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h55);  cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h56);  cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h100); cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h101); cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0); cycle();
    // flush_req held through flush_done starts a second sweep
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0); repeat (6) cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0); repeat (2) cycle();
    // reset during sweep idx 1 with a resolve waiting
    drive(1'b1, 1'b0, '0, '0, '0, 1'b1, 20'h100); repeat (2) cycle();
    start_reset(); cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h100); cycle();
    rst_n = 1'b1; repeat (4) cycle();
    // reset while a response is pending drops it
    drive(1'b0, 1'b1, 20'h56, 8'h3C, 22'h2AAAA, 1'b0, '0); cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 20'h56); cycle();
    start_reset(); drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0); cycle();
    rst_n = 1'b1; repeat (3) cycle();
    // randomized traffic over a small page pool
    flush_pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_done) flush_pending = 1'b0;
      else if (!flush_pending && $urandom_range(0, 40) == 0) flush_pending = 1'b1;
      drive(flush_pending, 1'($urandom_range(0, 2) == 0), pool[$urandom_range(0, 7)], 8'($urandom),
            22'($urandom), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)]);
      cycle();
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0); repeat (4) cycle();
`ifdef ARMLEOCPU_TLB_SEQ_STATS_EN
    @(negedge clk);
    check("stat_hits", 64'(stat_hits), 64'(hits));
    check("stat_misses", 64'(stat_misses), 64'(misses));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/armleocpu_tlb_sequencer.md
# armleocpu_tlb_sequencer

Controller in front of `armleocpu_tlb` that owns the TLB command port.
- Arbitrates between a page-table-walker refill writer and an address-translation resolve requester.
- Sequences full TLB invalidation (set-by-set sweep) for SFENCE.VMA and after reset.
- Returns registered-latency resolve responses.
- Sits between the fetch/load-store units, the PTW and the TLB instance.

## Interface
Parameters:
- ENTRIES_W, 1, log2 of TLB set count; must match the attached TLB.

Ports:
- clk  in  1  clock; all flops rise-edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_req  in  1  request full invalidation; level, held until flush_done.
- flush_done  out  1  one-cycle pulse when sweep completes.
- resolve_valid  in  1  resolve request.
- resolve_ready  out  1  resolve accepted when valid&&ready.
- resolve_vaddr  in  20  virtual page number to resolve.
- resp_valid  out  1  response valid, one cycle.
- resp_hit  out  1  TLB hit.
- resp_accesstag  out  8  access tag of hit entry.
- resp_phys  out  22  physical page number of hit entry.
- write_valid  in  1  refill write request.
- write_ready  out  1  write accepted when valid&&ready.
- write_vaddr  in  20  virtual page number to write.
- write_accesstag  in  8  access tag to write.
- write_phys  in  22  physical page number to write.
- tlb_command  out  2  `TLB_CMD_*` from armleocpu_defines.vh.
- tlb_invalidate_set_index  out  ENTRIES_W  set index during INVALIDATE.
- tlb_virtual_address  out  20  resolve address.
- tlb_virtual_address_w, tlb_accesstag_w, tlb_phys_w  out  20/8/22  write data.
- tlb_hit, tlb_accesstag_r, tlb_phys_r  in  1/8/22  TLB resolve outputs.

## Operation
- States: FLUSH, IDLE.
- FLUSH: tlb_command=INVALIDATE, tlb_invalidate_set_index=idx. idx increments each cycle. At idx=2^ENTRIES_W-1 the sequencer goes to IDLE, idx clears to 0, and flush_done pulses the following cycle (1 cycle). resolve_ready=write_ready=0 throughout.
- IDLE, priority per cycle:
  - flush_req: transition to FLUSH next cycle. The current cycle issues NONE and readies are 0.
  - Else write_valid: write_ready=1, tlb_command=WRITE with write_* driven to tlb_*_w.
  - Else resolve_valid: resolve_ready=1, tlb_command=RESOLVE, tlb_virtual_address=resolve_vaddr.
  - Else tlb_command=NONE.
- At most one TLB command per cycle; readies are combinational from state and request valids; resolve_ready never high while write_valid or flush_req is high.
- Response: resp_valid is registered from the resolve handshake. resp_hit/accesstag/phys pass combinationally from tlb_* outputs in the resp_valid cycle; they are forced to 0 when resp_valid=0.
- Write then resolve of same vaddr on consecutive cycles: resolve returns the new entry.
- flush_req held after flush_done: a new sweep starts. Requesters deassert flush_req on flush_done.

## Timing
- Reset: state=FLUSH, idx=0, resp_valid=0, flush_done=0.
  - Outputs during reset: tlb_command=INVALIDATE, readies 0, resp_* 0, tlb write/address outputs 0.
  - The first cycle after rst_n rises performs the invalidate of set 0. The post-reset sweep pulses flush_done too.
- Flush latency: 2^ENTRIES_W cycles of INVALIDATE, then flush_done. First request is accepted in the flush_done cycle.
- Resolve latency: handshake in cycle N → resp_valid in cycle N+1. Back-to-back resolves give one response per cycle.
- Write: single cycle, no response.
- Reset mid-sweep: abort and restart from idx=0; a pending response is dropped.

## Configuration
- ARMLEOCPU_TLB_SEQ_STATS_EN defined: adds outputs stat_hits and stat_misses, 32 bits each.
  - Each counter increments on resp_valid with resp_hit=1 or 0 respectively.
  - Saturating at 32'hFFFFFFFF; both reset to 0; not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, ENTRIES_W=1 → INVALIDATE idx 0, then idx 1, flush_done pulses on cycle 3, readies 0 until then.
- Writes 100→F5, 101→F5, 55→FE, 56→F5 (tag FF) → resolves of 55, 56, 100, 101 each give resp_valid next cycle, hit=1, tag=FF, phys FE/F5/F5/F5.
- write_valid and resolve_valid together → WRITE issued, resolve_ready=0 that cycle, resolve accepted next cycle.
- flush_req after the writes → two INVALIDATE cycles, flush_done, then resolves of 55, 56, 100, 101 → hit=0.
- rst_n low during sweep idx 1 with resolve pending → resp_valid=0, sweep restarts at idx 0.
- STATS_EN: 3 hits and 2 misses → stat_hits=3, stat_misses=2.
